// File: rtl/alu_wb_stage_if.sv
// rtl/alu_wb_stage_if.sv - handshake bundle between ALU, writeback stage and register-file write port
//
// Purpose: groups the upstream (ALU -> stage) and downstream (stage -> register
// file) valid/ready streams of alu_wb_stage into one interface.
//
// Signals:
//   in_valid/in_ready     upstream handshake
//   in_result             ALU result (8 bits)
//   in_flag_z/n/c/v       ALU flags
//   in_flag_mask          per-flag update enables [3]=Z [2]=N [1]=C [0]=V
//   in_rd/in_rd_we        destination register index and write enable
//   out_valid/out_ready   downstream handshake
//   out_result/out_rd/out_rd_we  head entry toward the register file
//
// Modports:
//   master - the environment (ALU + register file) side
//   slave  - the alu_wb_stage side

interface alu_wb_stage_if #(
  parameter int RF_ADDR_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_result;
  logic                 in_flag_z;
  logic                 in_flag_n;
  logic                 in_flag_c;
  logic                 in_flag_v;
  logic [3:0]           in_flag_mask;
  logic [RF_ADDR_W-1:0] in_rd;
  logic                 in_rd_we;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_result;
  logic [RF_ADDR_W-1:0] out_rd;
  logic                 out_rd_we;

  modport master (
    output in_valid, in_result, in_flag_z, in_flag_n, in_flag_c, in_flag_v,
           in_flag_mask, in_rd, in_rd_we, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, in_result, in_flag_z, in_flag_n, in_flag_c, in_flag_v,
           in_flag_mask, in_rd, in_rd_we, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_rd_we
  );
endinterface

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU execute/writeback stage with 2-entry skid buffer and status register
//
// Purpose: registers ALU results into a main/skid buffer pair toward the
// register-file write port, maintains the {Z,N,C,V} status register under a
// per-flag mask (updated at accept time), and returns the carry to the ALU.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all buffered entries
//   bus        alu_wb_stage_if.slave (in_* upstream, out_* downstream)
//   status     architectural flags {Z,N,C,V}
//   carry_out  status[1], wired to the ALU carry_in
//   fwd_valid/fwd_rd/fwd_result  forwarding of the newest pending write
//
// Configuration: define ALU_WB_FWD_EN to build the forwarding outputs;
// otherwise fwd_* are tied to 0.

module alu_wb_stage #(
  parameter int RF_ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  alu_wb_stage_if.slave        bus,
  output logic [3:0]           status,
  output logic                 carry_out,
  output logic                 fwd_valid,
  output logic [RF_ADDR_W-1:0] fwd_rd,
  output logic [7:0]           fwd_result
);

  // Main entry is the head and drives out_*; skid catches one entry while
  // the head is stalled so in_ready can be a plain register.
  logic                 main_valid, main_valid_n;
  logic [7:0]           main_result, main_result_n;
  logic [RF_ADDR_W-1:0] main_rd, main_rd_n;
  logic                 main_we, main_we_n;
  logic                 skid_valid, skid_valid_n;
  logic [7:0]           skid_result, skid_result_n;
  logic [RF_ADDR_W-1:0] skid_rd, skid_rd_n;
  logic                 skid_we, skid_we_n;
  logic                 in_ready_q;
  logic [3:0]           status_n;
  logic [3:0]           in_flags;
  logic                 accept;
  logic                 drain;

  assign in_flags = {bus.in_flag_z, bus.in_flag_n, bus.in_flag_c, bus.in_flag_v};
  assign accept   = bus.in_valid && in_ready_q && !flush;
  assign drain    = main_valid && bus.out_ready;

  always_comb begin
    main_valid_n  = main_valid;
    main_result_n = main_result;
    main_rd_n     = main_rd;
    main_we_n     = main_we;
    skid_valid_n  = skid_valid;
    skid_result_n = skid_result;
    skid_rd_n     = skid_rd;
    skid_we_n     = skid_we;

    // in_ready_q is always !skid_valid, so accept never coincides with a
    // full skid; the branches below are therefore exhaustive.
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (drain && skid_valid) begin
      main_valid_n  = 1'b1;
      main_result_n = skid_result;
      main_rd_n     = skid_rd;
      main_we_n     = skid_we;
      skid_valid_n  = 1'b0;
    end else if (accept && (!main_valid || drain)) begin
      main_valid_n  = 1'b1;
      main_result_n = bus.in_result;
      main_rd_n     = bus.in_rd;
      main_we_n     = bus.in_rd_we;
    end else if (accept) begin
      skid_valid_n  = 1'b1;
      skid_result_n = bus.in_result;
      skid_rd_n     = bus.in_rd;
      skid_we_n     = bus.in_rd_we;
    end else if (drain) begin
      main_valid_n = 1'b0;
    end

    status_n = status;
    if (accept) begin
      status_n = (status & ~bus.in_flag_mask) | (in_flags & bus.in_flag_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid  <= 1'b0;
      main_result <= '0;
      main_rd     <= '0;
      main_we     <= 1'b0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_we     <= 1'b0;
      in_ready_q  <= 1'b1;
      status      <= 4'b0000;
    end else begin
      main_valid  <= main_valid_n;
      main_result <= main_result_n;
      main_rd     <= main_rd_n;
      main_we     <= main_we_n;
      skid_valid  <= skid_valid_n;
      skid_result <= skid_result_n;
      skid_rd     <= skid_rd_n;
      skid_we     <= skid_we_n;
      in_ready_q  <= !skid_valid_n;
      status      <= status_n;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = main_valid;
  assign bus.out_result = main_result;
  assign bus.out_rd     = main_rd;
  assign bus.out_rd_we  = main_valid && main_we;
  assign carry_out      = status[1];

`ifdef ALU_WB_FWD_EN
  // Registered from the buffer's next state so fwd_* line up with the
  // buffer contents and have no combinational path from in_*.
  logic                 fwd_valid_n;
  logic [RF_ADDR_W-1:0] fwd_rd_n;
  logic [7:0]           fwd_result_n;

  always_comb begin
    if (skid_valid_n) begin
      fwd_valid_n  = skid_we_n;
      fwd_rd_n     = skid_rd_n;
      fwd_result_n = skid_result_n;
    end else begin
      fwd_valid_n  = main_valid_n && main_we_n;
      fwd_rd_n     = main_rd_n;
      fwd_result_n = main_result_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid  <= 1'b0;
      fwd_rd     <= '0;
      fwd_result <= '0;
    end else begin
      fwd_valid  <= fwd_valid_n;
      fwd_rd     <= fwd_rd_n;
      fwd_result <= fwd_result_n;
    end
  end
`else
  assign fwd_valid  = 1'b0;
  assign fwd_rd     = '0;
  assign fwd_result = '0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - scoreboard testbench for alu_wb_stage

module tb_alu_wb_stage;

  typedef struct {
    logic [7:0] res;
    logic [2:0] rd;
    logic       we;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] status;
  logic       carry_out;
  logic       fwd_valid;
  logic [2:0] fwd_rd;
  logic [7:0] fwd_result;

  alu_wb_stage_if #(.RF_ADDR_W(3)) bus ();

  alu_wb_stage #(.RF_ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus.slave),
    .status     (status),
    .carry_out  (carry_out),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_result (fwd_result)
  );

  int   checks = 0;
  int   failures = 0;
  ent_t q[$];
  logic [3:0] exp_status = 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, decide acceptance from the
  // handshake rule and update the reference model.
  task automatic drive(input bit v, input logic [7:0] res, input logic [3:0] flg,
                       input logic [3:0] mask, input logic [2:0] rd, input bit we,
                       input bit ord, input bit fl, output bit acc);
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_result    = res;
    bus.in_flag_z    = flg[3];
    bus.in_flag_n    = flg[2];
    bus.in_flag_c    = flg[1];
    bus.in_flag_v    = flg[0];
    bus.in_flag_mask = mask;
    bus.in_rd        = rd;
    bus.in_rd_we     = we;
    bus.out_ready    = ord;
    flush            = fl;
    #1;
    acc = rst_n && v && bus.in_ready && !fl;
    if (rst_n && fl) q.delete();
    if (acc) begin
      q.push_back('{res: res, rd: rd, we: we});
      for (int i = 0; i < 4; i++) if (mask[i]) exp_status[i] = flg[i];
    end
  endtask

  task automatic idle(input int n, input bit ord);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0, ord, 1'b0, a);
  endtask

  task automatic send(input logic [7:0] res, input logic [3:0] flg, input logic [3:0] mask,
                      input logic [2:0] rd, input bit we, input bit ord);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      drive(1'b1, res, flg, mask, rd, we, ord, 1'b0, a);
      n++;
    end
    if (!a) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      idle(1, 1'b1);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every register-file handshake.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("out_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("out_result", bus.out_result, e.res);
          check("out_rd", bus.out_rd, e.rd);
          check("out_rd_we", bus.out_rd_we, e.we);
        end
      end
    end
  end

  // State monitor: occupancy, status and forwarding after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("status", status, exp_status);
      check("carry_out", carry_out, exp_status[1]);
      check("out_valid", bus.out_valid, q.size() != 0);
      check("in_ready", bus.in_ready, q.size() < 2);
`ifdef ALU_WB_FWD_EN
      if (q.size() != 0 && q[$].we) begin
        check("fwd_valid", fwd_valid, 1);
        check("fwd_rd", fwd_rd, q[$].rd);
        check("fwd_result", fwd_result, q[$].res);
      end else begin
        check("fwd_valid", fwd_valid, 0);
      end
`else
      check("fwd_zero", {fwd_valid, fwd_rd, fwd_result}, 0);
`endif
    end
  end

  initial begin
    bit a;
    rst_n            = 1'b0;
    flush            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_result    = 8'h00;
    bus.in_flag_z    = 1'b0;
    bus.in_flag_n    = 1'b0;
    bus.in_flag_c    = 1'b0;
    bus.in_flag_v    = 1'b0;
    bus.in_flag_mask = 4'h0;
    bus.in_rd        = 3'd0;
    bus.in_rd_we     = 1'b0;
    bus.out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_status", status, 4'b0000);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Streaming at full rate: every op accepted on its first cycle.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i * 8'h11), 4'hF, 4'h0, 3'(i), 1'b1, 1'b1, 1'b0, a);
      check("stream_accept", a, 1);
    end
    drain_all();

    // Backpressure: two entries held, third refused until drain.
    drive(1'b1, 8'hA5, 4'h0, 4'h0, 3'd6, 1'b1, 1'b0, 1'b0, a);
    check("hold_acc0", a, 1);
    drive(1'b1, 8'h5A, 4'h0, 4'h0, 3'd7, 1'b0, 1'b0, 1'b0, a);
    check("hold_acc1", a, 1);
    drive(1'b1, 8'hFF, 4'h0, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, a);
    check("hold_refused", a, 0);
    check("hold_head", bus.out_result, 8'hA5);
    check("hold_in_ready", bus.in_ready, 0);
    send(8'hFF, 4'h0, 4'h0, 3'd2, 1'b1, 1'b1);
    drain_all();

    // Asynchronous reset with two entries held.
    send(8'h12, 4'h0, 4'h0, 3'd1, 1'b1, 1'b0);
    send(8'h34, 4'h0, 4'h0, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    q.delete();
    exp_status = 4'b0000;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(1, 1'b0);
    check("arst_in_ready", bus.in_ready, 1);

    // Flag masking from a clean status.
    send(8'h01, 4'b1111, 4'b0010, 3'd1, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("mask_status", status, 4'b0010);
    check("mask_carry", carry_out, 1);
    send(8'h02, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("nomask_status", status, 4'b0010);
    drain_all();

    // Flush with two entries buffered and a concurrent input.
    send(8'h21, 4'h0, 4'h0, 3'd3, 1'b1, 1'b0);
    send(8'h43, 4'h0, 4'h0, 3'd4, 1'b1, 1'b0);
    drive(1'b1, 8'h99, 4'b0000, 4'b1111, 3'd5, 1'b1, 1'b0, 1'b1, a);
    idle(1, 1'b0);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_status", status, 4'b0010);
    idle(1, 1'b1);

    // Forwarding of the newest pending write.
    send(8'h7E, 4'h0, 4'h0, 3'd5, 1'b1, 1'b0);
    idle(1, 1'b0);
`ifdef ALU_WB_FWD_EN
    check("fwd_main", {fwd_valid, fwd_rd, fwd_result}, {1'b1, 3'd5, 8'h7E});
`else
    check("fwd_main", {fwd_valid, fwd_rd, fwd_result}, 0);
`endif
    send(8'h3C, 4'h0, 4'h0, 3'd6, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("fwd_skid_nowe", fwd_valid, 0);
    drain_all();

    // Randomized traffic with random backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      bit v, ord, fl;
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      ord = fl ? 1'b0 : ($urandom_range(0, 2) != 0);
      drive(v, 8'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
            ord, fl, a);
    end
    drain_all();
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Execute/writeback pipeline stage directly downstream of the combinational ALU.
- Registers the ALU result and destination-register info into a 2-entry skid buffer with a valid/ready handshake toward the register-file write port.
- Maintains the architectural status register (Z, N, C, V) under a per-flag update mask.
- Returns the registered carry to the ALU carry_in for ADC/SBC chains.

Parameters:
- RF_ADDR_W, 3, width of the destination-register index (8 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  ALU output valid this cycle.
- in_ready  output  1  stage can accept; registered.
- in_result  input  8  ALU result.
- in_flag_z, in_flag_n, in_flag_c, in_flag_v  input  1 each  ALU flags.
- in_flag_mask  input  4  flag update enables: [3]=Z, [2]=N, [1]=C, [0]=V.
- in_rd  input  RF_ADDR_W  destination register index.
- in_rd_we  input  1  result is to be written to the register file.
- out_valid  output  1  head entry valid.
- out_ready  input  1  register file accepts the head entry.
- out_result  output  8  head result.
- out_rd  output  RF_ADDR_W  head destination.
- out_rd_we  output  1  head write enable (qualified by out_valid).
- status  output  4  architectural flags {Z,N,C,V}.
- carry_out  output  1  equals status[1]; wired to the ALU carry_in.
- fwd_valid  output  1  forwarding: a pending write exists (see Optional Feature).
- fwd_rd  output  RF_ADDR_W  forwarding destination.
- fwd_result  output  8  forwarding data.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid, out_valid=0, in_ready=1, status=4'b0000, carry_out=0. Data fields and fwd_* reset to 0.
- Accept condition: in_valid && in_ready && !flush.
- Storage is a main entry (head, drives out_*) and a skid entry.
  - Accept with main empty, or main draining this cycle (out_valid && out_ready) and skid empty: the entry goes to main.
  - Accept with main held (out_valid && !out_ready): the entry goes to skid.
  - Drain with skid valid: skid moves to main in the same cycle.
- in_ready is registered and equals !skid_valid for the next cycle. In-order delivery is always preserved. No combinational path from out_ready to in_ready.
- Latency: accepted entry appears on out_* the following cycle. Throughput is 1 per cycle when out_ready is held high.
- Status update happens at accept time, not at drain.
  - For each mask bit set, the corresponding status bit takes the in_flag value on the next edge; unmasked bits hold.
  - carry_out therefore reflects the previous accepted op on the very next cycle, which supports back-to-back ADC chains.
- Entries with in_rd_we=0 still occupy the buffer and are presented with out_rd_we=0. The consumer handshakes them normally.
- flush: both entries are invalidated on the next edge. An input presented in the same cycle is discarded and does not update status. status itself is never cleared by flush. in_ready returns to 1 the cycle after the flush.
- Simultaneous accept and drain with one entry held: the net occupancy is unchanged and the new entry becomes the head.
- Outputs out_* hold stable while out_valid && !out_ready.
- rst_n asserted mid-transfer: in-flight entries are lost and there is no partial write. out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined:
  - fwd_valid=1 when the newest buffered entry has rd_we=1. The newest entry is skid if valid, else main.
  - fwd_rd and fwd_result present that entry, so the upstream operand mux can bypass the register file.
  - fwd_* are registered and carry no combinational path from in_*.
- Undefined: fwd_valid, fwd_rd and fwd_result are tied to 0 and no forwarding logic is synthesized.

Test Plan:
- Reset then idle: status=0000, in_ready=1, out_valid=0. Assert rst_n low mid-stream with 2 entries held -> out_valid=0 immediately; in_ready=1 after release.
- Stream 4 ops with out_ready=1 (results 0x11, 0x22, 0x33, 0x44; rd 1-4) -> same values on out_* one cycle later each, one per cycle, in_ready never drops.
- Hold out_ready=0 and send 0xA5, then 0x5A -> out_result=0xA5 held and in_ready=0. Third input 0xFF is not accepted. Raise out_ready -> 0xA5, 0x5A, 0xFF in order.
- Flag masking from status=0000:
  - Accept flags Z=1 N=1 C=1 V=1 with mask=0010 -> status=0010 and carry_out=1 the next cycle.
  - Then accept C=0 with mask=0000 -> status unchanged.
- Flush with 2 entries buffered and a concurrent input (flags C=0, mask=1111) -> out_valid=0 next cycle, status unchanged, input not delivered.
- ALU_WB_FWD_EN defined:
  - Accept rd=5, result 0x7E, we=1 while out_ready=0 -> fwd_valid=1, fwd_rd=5, fwd_result=0x7E next cycle.
  - Accept a we=0 entry into skid -> fwd_valid=0.
- ALU_WB_FWD_EN undefined: fwd_* stay 0 throughout.
